// File: rtl/cacheline_adapter_if.sv
// Bundle of the cache-side line port (dfp_*) and the 64-bit burst memory port (bmem_*).
// The adapter connects through the slave modport; the controller/memory environment uses master.
interface cacheline_adapter_if #(
    parameter int LINE_WIDTH = 256,
    parameter int BEAT_WIDTH = 64,
    parameter int ADDR_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0] dfp_addr;
    logic                  dfp_read;
    logic                  dfp_write;
    logic [LINE_WIDTH-1:0] dfp_wdata;
    logic [LINE_WIDTH-1:0] dfp_rdata;
    logic                  dfp_resp;

    logic [ADDR_WIDTH-1:0] bmem_addr;
    logic                  bmem_read;
    logic                  bmem_write;
    logic [BEAT_WIDTH-1:0] bmem_wdata;
    logic                  bmem_ready;
    logic [BEAT_WIDTH-1:0] bmem_rdata;
    logic                  bmem_rvalid;

    modport slave (
        input  dfp_addr, dfp_read, dfp_write, dfp_wdata,
        output dfp_rdata, dfp_resp,
        output bmem_addr, bmem_read, bmem_write, bmem_wdata,
        input  bmem_ready, bmem_rdata, bmem_rvalid
    );

    modport master (
        output dfp_addr, dfp_read, dfp_write, dfp_wdata,
        input  dfp_rdata, dfp_resp,
        input  bmem_addr, bmem_read, bmem_write, bmem_wdata,
        output bmem_ready, bmem_rdata, bmem_rvalid
    );
endinterface

// File: rtl/cacheline_adapter.sv
// Converts whole-line cache requests into 4-beat bursts on the memory port:
// writebacks are serialized beat by beat, fetches are reassembled into one line.
module cacheline_adapter #(
    parameter int LINE_WIDTH = 256,
    parameter int BEAT_WIDTH = 64,
    parameter int ADDR_WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst,
    cacheline_adapter_if.slave bus
);
    localparam int BEATS = LINE_WIDTH / BEAT_WIDTH;
    localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [CNT_W-1:0]      LAST_BEAT   = CNT_W'(BEATS - 1);
    localparam logic [ADDR_WIDTH-1:0] OFFSET_MASK = ADDR_WIDTH'(LINE_WIDTH / 8 - 1);

    typedef enum logic [2:0] {
        LINE_IDLE,
        WAIT,
        SERIALIZE,
        DESERIALIZE,
        DESERIALIZE_DONE
    } cacheline_state_t;

    cacheline_state_t state, state_next;
    logic [CNT_W-1:0] cnt, cnt_next;
    logic             op_write;
    logic [ADDR_WIDTH-1:0]            addr_q;
    logic [BEATS-1:0][BEAT_WIDTH-1:0] wdata_q;
    logic [BEATS-1:0][BEAT_WIDTH-1:0] rdata_q;

    logic req_take;
    logic beat_store;

    function automatic logic [ADDR_WIDTH-1:0] line_align(input logic [ADDR_WIDTH-1:0] a);
        return a & ~OFFSET_MASK;
    endfunction

    // Requests are only looked at in LINE_IDLE, so a request still held during
    // the response cycle can never start a second burst.
    assign req_take   = (state == LINE_IDLE) && (bus.dfp_write || bus.dfp_read);
    assign beat_store = (state == DESERIALIZE) && bus.bmem_rvalid;

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        unique case (state)
            LINE_IDLE: begin
                if (req_take) begin
                    state_next = WAIT;
                    cnt_next   = '0;
                end
            end
            WAIT: begin
                if (bus.bmem_ready) begin
                    if (op_write) begin
                        state_next = SERIALIZE;
                        cnt_next   = CNT_W'(1);
                    end else begin
                        state_next = DESERIALIZE;
                    end
                end
            end
            SERIALIZE: begin
                if (bus.bmem_ready) begin
                    if (cnt == LAST_BEAT) state_next = DESERIALIZE_DONE;
                    cnt_next = cnt + 1'b1;
                end
            end
            DESERIALIZE: begin
                if (bus.bmem_rvalid) begin
                    if (cnt == LAST_BEAT) state_next = DESERIALIZE_DONE;
                    cnt_next = cnt + 1'b1;
                end
            end
            DESERIALIZE_DONE: state_next = LINE_IDLE;
            default:          state_next = LINE_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= LINE_IDLE;
            cnt      <= '0;
            op_write <= 1'b0;
            addr_q   <= '0;
            rdata_q  <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            if (req_take) begin
                op_write <= bus.dfp_write;
                addr_q   <= line_align(bus.dfp_addr);
            end
            if (beat_store) rdata_q[cnt] <= bus.bmem_rdata;
        end
    end

    // Writeback line is pure data; bmem_wdata is gated so its contents are never visible idle.
    always_ff @(posedge clk) begin
        if ((state == LINE_IDLE) && bus.dfp_write) wdata_q <= bus.dfp_wdata;
    end

    always_comb begin
        bus.bmem_read  = 1'b0;
        bus.bmem_write = 1'b0;
        bus.bmem_wdata = '0;
        if ((state == WAIT) || (state == SERIALIZE)) begin
            if (op_write) begin
                bus.bmem_write = 1'b1;
                bus.bmem_wdata = wdata_q[cnt];
            end else begin
                bus.bmem_read = (state == WAIT);
            end
        end
    end

    assign bus.bmem_addr = addr_q;
    assign bus.dfp_rdata = rdata_q;
    assign bus.dfp_resp  = (state == DESERIALIZE_DONE);
endmodule

// File: tb/tb_cacheline_adapter.sv
// Bench for cacheline_adapter: vector table of line transactions against a beat-level memory
// model, with a scoreboard of expected lines and write beats, plus a reset-mid-burst sequence.
module tb_cacheline_adapter;
    localparam int LW = 256;
    localparam int BW = 64;
    localparam int AW = 32;
    localparam int NV = 8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    cacheline_adapter_if #(.LINE_WIDTH(LW), .BEAT_WIDTH(BW), .ADDR_WIDTH(AW)) bus ();

    cacheline_adapter #(.LINE_WIDTH(LW), .BEAT_WIDTH(BW), .ADDR_WIDTH(AW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        bit          is_write;
        bit          both;
        bit          b2b;
        logic [31:0] addr;
        logic [255:0] wdata;
        logic [7:0]  stall_mask;  // bit i: bmem_ready low in cycle T+1+i
        int          gap;         // idle cycles between read beats
        int          exp_lat;
        logic [31:0] exp_baddr;
        int          exp_rd_cyc;
        int          exp_wr_cyc;
    } vec_t;

    vec_t vecs [NV];
    int n_checks = 0;
    int n_errors = 0;
    logic [63:0]  mem [int];
    logic [255:0] exp_line_q [$];
    logic [63:0]  exp_beat_q [$];
    logic [255:0] last_rdata;

    function automatic vec_t mkv(bit w, bit both, bit b2b, logic [31:0] addr, logic [255:0] wd,
                                 logic [7:0] sm, int gap, int lat, logic [31:0] ba, int rdc, int wrc);
        vec_t v;
        v.is_write = w; v.both = both; v.b2b = b2b; v.addr = addr; v.wdata = wd;
        v.stall_mask = sm; v.gap = gap; v.exp_lat = lat; v.exp_baddr = ba;
        v.exp_rd_cyc = rdc; v.exp_wr_cyc = wrc;
        return v;
    endfunction

    function automatic logic [63:0] mem_rd(int a);
        if (mem.exists(a)) return mem[a];
        return {32'hC0DE_0000 ^ 32'(a), ~32'(a)};
    endfunction

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, " dfp_rdata"}, bus.dfp_rdata, '0);
        chk({tag, " dfp_resp"}, bus.dfp_resp, 0);
        chk({tag, " bmem_addr"}, bus.bmem_addr, 0);
        chk({tag, " bmem_rd_wr"}, {bus.bmem_read, bus.bmem_write}, 0);
        chk({tag, " bmem_wdata"}, bus.bmem_wdata, 0);
    endtask

    // Called at a negedge; that cycle is T. Returns at the negedge of the cycle after dfp_resp.
    task automatic run_vec(input vec_t v, input string tag);
        int base, k, resp_k, rd_cyc, wr_cyc, rd_pending, rd_wait, rd_idx, wr_idx;
        logic ready;
        bit addr_seen;
        logic [255:0] exp;
        base = int'((v.addr & ~32'h1f) >> 3);
        bus.dfp_addr  = v.addr;
        bus.dfp_write = v.is_write;
        bus.dfp_read  = !v.is_write || v.both;
        bus.dfp_wdata = v.wdata;
        if (v.is_write) begin
            for (int i = 0; i < 4; i++) exp_beat_q.push_back(v.wdata[i*64 +: 64]);
            exp_line_q.push_back(last_rdata);
        end else begin
            exp = {mem_rd(base + 3), mem_rd(base + 2), mem_rd(base + 1), mem_rd(base)};
            exp_line_q.push_back(exp);
            last_rdata = exp;
        end
        k = 0; resp_k = -1; rd_cyc = 0; wr_cyc = 0;
        rd_pending = 0; rd_wait = 0; rd_idx = 0; wr_idx = 0; addr_seen = 0;
        while (resp_k < 0 && k < 40) begin
            @(negedge clk);
            k++;
            if (bus.dfp_resp) begin
                resp_k = k;
                chk({tag, " latency"}, k, v.exp_lat);
                if (exp_line_q.size() == 0) begin
                    n_checks++; n_errors++;
                    $display("FAIL %s rdata: unexpected dfp_resp, scoreboard empty", tag);
                end else begin
                    chk({tag, " rdata"}, bus.dfp_rdata, exp_line_q.pop_front());
                end
            end
            if (bus.bmem_read)  rd_cyc++;
            if (bus.bmem_write) wr_cyc++;
            if ((bus.bmem_read || bus.bmem_write) && !addr_seen) begin
                addr_seen = 1;
                chk({tag, " bmem_addr"}, bus.bmem_addr, v.exp_baddr);
            end
            ready = !(k <= 8 && v.stall_mask[k-1]);
            bus.bmem_ready  = ready;
            bus.bmem_rvalid = 1'b0;
            if (rd_pending > 0) begin
                if (rd_wait == 0) begin
                    bus.bmem_rvalid = 1'b1;
                    bus.bmem_rdata  = mem_rd(base + rd_idx);
                    rd_idx++;
                    rd_pending--;
                    rd_wait = v.gap;
                end else begin
                    rd_wait--;
                end
            end
            if (bus.bmem_read && ready) begin
                rd_pending = 4;
                rd_wait    = 0;
            end
            if (bus.bmem_write && ready) begin
                if (exp_beat_q.size() == 0) begin
                    n_checks++; n_errors++;
                    $display("FAIL %s wbeat: extra beat %h", tag, bus.bmem_wdata);
                end else begin
                    chk({tag, " wbeat"}, bus.bmem_wdata, exp_beat_q.pop_front());
                end
                mem[base + wr_idx] = bus.bmem_wdata;
                wr_idx++;
            end
        end
        if (resp_k < 0) begin
            n_checks++; n_errors++;
            $display("FAIL %s timeout: no dfp_resp within 40 cycles", tag);
        end
        bus.bmem_ready  = 1'b0;
        bus.bmem_rvalid = 1'b0;
        chk({tag, " rd_cycles"}, rd_cyc, v.exp_rd_cyc);
        chk({tag, " wr_cycles"}, wr_cyc, v.exp_wr_cyc);
        @(negedge clk);
        chk({tag, " resp_one_cycle"}, bus.dfp_resp, 0);
        chk({tag, " bmem_quiet"}, {bus.bmem_read, bus.bmem_write}, 0);
    endtask

    task automatic idle_cycles(input int n);
        bus.dfp_read  = 1'b0;
        bus.dfp_write = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            chk("idle bmem_rd_wr", {bus.bmem_read, bus.bmem_write}, 0);
        end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t fin;
        vecs[0] = mkv(0, 0, 0, 32'h0000_1234, '0, 8'h00, 0, 6, 32'h0000_1220, 1, 0);
        vecs[1] = mkv(1, 0, 0, 32'h0000_1240,
                      {64'hD3D3_3333_0000_0003, 64'hD2D2_2222_0000_0002,
                       64'hD1D1_1111_0000_0001, 64'hD0D0_0000_0000_0000},
                      8'h02, 0, 6, 32'h0000_1240, 0, 5);
        vecs[2] = mkv(0, 0, 0, 32'h0000_3300, '0, 8'h00, 1, 9, 32'h0000_3300, 1, 0);
        vecs[3] = mkv(1, 1, 0, 32'h0000_0400,
                      {64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210,
                       64'hAAAA_5555_AAAA_5555, 64'h5555_AAAA_5555_AAAA},
                      8'h00, 0, 5, 32'h0000_0400, 0, 4);
        vecs[4] = mkv(0, 0, 0, 32'h0000_05E7, '0, 8'h01, 0, 7, 32'h0000_05E0, 2, 0);
        vecs[5] = mkv(1, 0, 0, 32'h0000_6000,
                      {64'h6666_0000_0000_0003, 64'h6666_0000_0000_0002,
                       64'h6666_0000_0000_0001, 64'h6666_0000_0000_0000},
                      8'h00, 0, 5, 32'h0000_6000, 0, 4);
        vecs[6] = mkv(0, 0, 1, 32'h0000_601F, '0, 8'h00, 0, 6, 32'h0000_6000, 1, 0);
        vecs[7] = mkv(1, 0, 0, 32'h0000_7008,
                      {64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0001,
                       64'h0000_0000_0000_0000, 64'h7777_7777_7777_7777},
                      8'h0C, 0, 7, 32'h0000_7000, 0, 6);

        mem[32'h1220 >> 3]       = 64'h1111_1111_1111_1111;
        mem[(32'h1220 >> 3) + 1] = 64'h2222_2222_2222_2222;
        mem[(32'h1220 >> 3) + 2] = 64'h3333_3333_3333_3333;
        mem[(32'h1220 >> 3) + 3] = 64'h4444_4444_4444_4444;

        rst = 1'b1;
        bus.dfp_addr = '0; bus.dfp_read = 1'b0; bus.dfp_write = 1'b0; bus.dfp_wdata = '0;
        bus.bmem_ready = 1'b0; bus.bmem_rdata = '0; bus.bmem_rvalid = 1'b0;
        last_rdata = '0;
        repeat (3) @(negedge clk);
        chk_reset_outputs("reset");
        rst = 1'b0;
        @(negedge clk);
        chk_reset_outputs("post_reset");

        for (int i = 0; i < NV; i++) begin
            run_vec(vecs[i], $sformatf("vec%0d", i));
            if (!(i + 1 < NV && vecs[i+1].b2b)) idle_cycles(2);
        end
        chk("vec0 line literal check",
            {mem_rd(32'h1220 >> 3) , 192'h0} , {64'h1111_1111_1111_1111, 192'h0});

        // Reset in the middle of a fetch, after two beats have landed.
        bus.dfp_addr = 32'h0000_2040; bus.dfp_read = 1'b1;
        @(negedge clk);
        chk("midrst bmem_read", bus.bmem_read, 1);
        bus.bmem_ready = 1'b1;
        @(negedge clk);
        bus.bmem_ready = 1'b0; bus.bmem_rvalid = 1'b1; bus.bmem_rdata = 64'hBAD0_0000_0000_0000;
        @(negedge clk);
        bus.bmem_rdata = 64'hBAD1_1111_1111_1111;
        @(negedge clk);
        bus.bmem_rvalid = 1'b0; bus.dfp_read = 1'b0;
        rst = 1'b1;
        #1;
        chk_reset_outputs("midrst");
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 2; i++) begin
            bus.bmem_rvalid = 1'b1;
            bus.bmem_rdata  = 64'hDEAD_0000_0000_0000 | 64'(i);
            @(negedge clk);
            chk("stray resp", bus.dfp_resp, 0);
            chk("stray rdata", bus.dfp_rdata, '0);
            chk("stray bmem_read", bus.bmem_read, 0);
        end
        bus.bmem_rvalid = 1'b0;
        last_rdata = '0;
        idle_cycles(1);

        fin = mkv(0, 0, 0, 32'h0000_1234, '0, 8'h00, 2, 12, 32'h0000_1220, 1, 0);
        run_vec(fin, "after_reset_read");
        chk("after_reset_read literal", bus.dfp_rdata,
            {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
             64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111});
        idle_cycles(2);
        chk("scoreboard lines drained", exp_line_q.size(), 0);
        chk("scoreboard beats drained", exp_beat_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule

// File: doc/cacheline_adapter.md
# cacheline_adapter

Bridges one cache controller's whole-line requests to the 64-bit burst memory port. A write sends one 256-bit line to memory as four beats. A read collects four returned beats into one line. The adapter sits directly downstream of the cache controller's WRITEBACK/FETCH/FETCH_WAIT states and steps through the shared `cache_types::cacheline_state_t` encoding.

## Interface
- `LINE_WIDTH`, 256, cacheline width in bits
- `BEAT_WIDTH`, 64, memory beat width; `BEATS = LINE_WIDTH/BEAT_WIDTH` (4)
- `ADDR_WIDTH`, 32, byte address width
- `clk`  in  1  single clock, all state on rising edge
- `rst`  in  1  reset, asynchronous, active-high
- `dfp_addr`  in  ADDR_WIDTH  line address from the controller; low `log2(LINE_WIDTH/8)` bits are ignored
- `dfp_read`  in  1  line fetch request
- `dfp_write`  in  1  line writeback request
- `dfp_wdata`  in  LINE_WIDTH  writeback line
- `dfp_rdata`  out  LINE_WIDTH  fetched line
- `dfp_resp`  out  1  one-cycle completion pulse
- `bmem_addr`  out  ADDR_WIDTH  burst address, line-aligned
- `bmem_read`  out  1  burst read request
- `bmem_write`  out  1  write beat valid
- `bmem_wdata`  out  BEAT_WIDTH  write beat
- `bmem_ready`  in  1  memory accepts the request or beat this cycle
- `bmem_rdata`  in  BEAT_WIDTH  read beat
- `bmem_rvalid`  in  1  read beat valid

## Operation
- **State register:** uses `cacheline_state_t`: LINE_IDLE, WAIT, SERIALIZE, DESERIALIZE, DESERIALIZE_DONE. DESERIALIZE_DONE is the response state for both reads and writes.
- **LINE_IDLE:** requests are sampled here only.
  - If `dfp_write` is high: latch the aligned address, `dfp_wdata` and op=write, then go to WAIT.
  - Else if `dfp_read` is high: latch the aligned address and op=read, then go to WAIT.
  - Write has priority when both are high.
- **WAIT:** drives `bmem_addr`.
  - Read: drives `bmem_read=1`.
  - Write: drives `bmem_write=1` with `bmem_wdata` = beat 0 (bits [63:0]).
  - When `bmem_ready`: a read goes to DESERIALIZE; a write goes to SERIALIZE with beat counter = 1.
  - Otherwise hold, with all outputs stable.
- **SERIALIZE:** drives `bmem_write=1`, `bmem_wdata` = beat[counter], and `bmem_addr` held.
  - A beat advances only when `bmem_ready` is high; otherwise hold.
  - After beat `BEATS-1` is accepted, go to DESERIALIZE_DONE.
- **DESERIALIZE:** on each `bmem_rvalid`, store `bmem_rdata` into slot[counter] (beat 0 goes to the LSBs) and increment the counter.
  - Gaps in `bmem_rvalid` are allowed.
  - After slot `BEATS-1` is filled, go to DESERIALIZE_DONE.
- **DESERIALIZE_DONE:** `dfp_resp=1` for exactly one cycle, then go to LINE_IDLE.
  - Requests are not sampled in this state.
  - The controller holds its request until it sees `dfp_resp`, then drops it.
- **Read data:** `dfp_rdata` is the assembled line register. It is valid from DESERIALIZE_DONE and held until the next read overwrites it. Writes do not modify it.
- **Counter:** `$clog2(BEATS)` bits, cleared on entry to WAIT.
- **Ignored inputs:** `bmem_rvalid` outside DESERIALIZE is ignored. `bmem_ready` outside WAIT/SERIALIZE is ignored.
- **Output gating:** `bmem_read`/`bmem_write` are never asserted outside WAIT/SERIALIZE.

## Timing
- **Reset values:** state=LINE_IDLE, counter=0, `dfp_rdata`=0, `dfp_resp`=0, `bmem_addr`=0, `bmem_read`=0, `bmem_write`=0, `bmem_wdata`=0.
- **Reset mid-burst:** the burst is abandoned. Straggling `bmem_rvalid` beats after release are ignored in LINE_IDLE.
- **Output timing:** all outputs decode from registered state, counter and latched data; there is no combinational path from `dfp_*` inputs to `bmem_*` outputs.
- **Read latency** (request sampled at cycle T, `bmem_ready` high, `bmem_rvalid` back-to-back from T+2):
  - WAIT/issue at T+1
  - beats at T+2..T+5
  - `dfp_resp` at T+6
  - minimum 6 cycles
- **Write latency** (`bmem_ready` always high):
  - beat 0 at T+1
  - beats 1–3 at T+2..T+4
  - `dfp_resp` at T+5
  - minimum 5 cycles
- **Stalls:** each cycle of `bmem_ready` low, or each `bmem_rvalid` gap, adds exactly one cycle.
- **Back-to-back:** the next request can be sampled at the earliest on the cycle after `dfp_resp`.

## Test plan
- **Read, no stalls:** read of 0x0000_1234; `bmem_addr`=0x0000_1220; beats 0x11..11, 0x22..22, 0x33..33, 0x44..44 → `dfp_rdata`={0x44..44, 0x33..33, 0x22..22, 0x11..11}, `dfp_resp` at T+6 for one cycle.
- **Write with stall:** `dfp_wdata`={D3,D2,D1,D0}; `bmem_ready` low in cycle T+2 → `bmem_wdata` sequence D0, D1, D1, D2, D3; `dfp_resp` at T+6; `dfp_rdata` unchanged.
- **Read with rvalid gaps:** one-cycle gaps between beats → beats land in the correct slots, `dfp_resp` 3 cycles later than the no-gap case, and `bmem_read` high only in the WAIT cycle.
- **Simultaneous requests:** `dfp_read`=`dfp_write`=1 in LINE_IDLE → write burst issued, no `bmem_read` pulse.
- **Reset mid-read:** assert `rst` after beat 1, then send 2 stray `bmem_rvalid` beats → outputs at reset values, state LINE_IDLE, `dfp_rdata`=0, no `dfp_resp`; a subsequent read completes correctly.
- **Back-to-back:** write then read of the same line, requests held until `dfp_resp` → second request sampled in the cycle after the first `dfp_resp`; the read returns the memory model's written line.
